// File: rtl/mem_responder.sv
// Main-memory responder for the snoopy MSI bus: serves BusRd/BusRdX after a fixed latency,
// absorbs flush writebacks and stays silent when a cache supplies the line cache-to-cache.
module mem_responder #(
    parameter int unsigned NUM_LINES       = 2,
    parameter int unsigned CACHE_LINE_SIZE = 128,
    parameter int unsigned MEM_LATENCY     = 3,
    localparam int unsigned ADDR_SIZE      = NUM_LINES
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [1:0]                 bus_msg_i,
    input  logic [ADDR_SIZE-1:0]       addr_i,
    input  logic [1:0]                 owner_i,
    input  logic                       flush_i,
    input  logic [CACHE_LINE_SIZE-1:0] flush_data_i,
    output logic [CACHE_LINE_SIZE-1:0] data_o,
    output logic                       data_valid_o,
    output logic [1:0]                 data_dst_o,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam logic [1:0] MsgRd   = 2'b01;
    localparam logic [1:0] MsgRdX  = 2'b10;
    localparam logic [1:0] MsgUpgr = 2'b11;
    localparam logic [3:0] LatLoad = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                     state_q;
    logic [3:0]                 cnt_q;
    logic [ADDR_SIZE-1:0]       addr_q;
    logic [1:0]                 owner_q;
    logic [CACHE_LINE_SIZE-1:0] data_q;
    logic                       valid_q;
    logic [1:0]                 dst_q;
    logic                       busy_q;
    logic                       err_q;
    logic [CACHE_LINE_SIZE-1:0] mem_q [NUM_LINES];

    logic [31:0]                addr_ext;
    logic                       addr_ok;
    logic                       is_read;
    logic                       rd_req;
    logic                       rd_accept;
    logic                       wr_en;
    logic                       err_set;
    logic                       fwd;
    logic [CACHE_LINE_SIZE-1:0] mem_rd;

    assign addr_ext = 32'(addr_i);

    always_comb begin
        addr_ok   = addr_ext < NUM_LINES;
        is_read   = (bus_msg_i == MsgRd) || (bus_msg_i == MsgRdX);
        rd_req    = is_read && !flush_i;
        rd_accept = rd_req && !busy_q && addr_ok;
        wr_en     = flush_i && (bus_msg_i != MsgUpgr) && addr_ok;
        err_set   = (flush_i && (bus_msg_i == MsgUpgr))
                  || (flush_i && (bus_msg_i != MsgUpgr) && !addr_ok)
                  || (rd_req && (busy_q || !addr_ok));
        // A write landing on the response edge must be seen by that response.
        fwd       = wr_en && (addr_i == addr_q);
    end

    always_comb begin
        mem_rd = '0;
        for (int unsigned k = 0; k < NUM_LINES; k++) begin
            if (addr_q == ADDR_SIZE'(k)) begin
                mem_rd = mem_q[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < NUM_LINES; k++) begin
                mem_q[k] <= CACHE_LINE_SIZE'(k);
            end
        end else if (wr_en) begin
            for (int unsigned k = 0; k < NUM_LINES; k++) begin
                if (addr_i == ADDR_SIZE'(k)) begin
                    mem_q[k] <= flush_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            owner_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            dst_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    if (rd_accept) begin
                        state_q <= StWait;
                        cnt_q   <= LatLoad;
                        addr_q  <= addr_i;
                        owner_q <= owner_i;
                        busy_q  <= 1'b1;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StResp;
                        data_q  <= fwd ? flush_data_i : mem_rd;
                        valid_q <= 1'b1;
                        dst_q   <= owner_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign data_dst_o   = dst_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, hand-written corner sequences and randomized traffic
// checked against a per-edge transaction model.
module tb_mem_responder;

    localparam int unsigned NL  = 2;
    localparam int unsigned CLS = 128;
    localparam int unsigned LAT = 3;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [1:0]     bus_msg_i;
    logic [1:0]     addr_i;
    logic [1:0]     owner_i;
    logic           flush_i;
    logic [CLS-1:0] flush_data_i;
    logic [CLS-1:0] data_o;
    logic           data_valid_o;
    logic [1:0]     data_dst_o;
    logic           busy_o;
    logic           err_o;

    mem_responder #(
        .NUM_LINES      (NL),
        .CACHE_LINE_SIZE(CLS),
        .MEM_LATENCY    (LAT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus_msg_i   (bus_msg_i),
        .addr_i      (addr_i),
        .owner_i     (owner_i),
        .flush_i     (flush_i),
        .flush_data_i(flush_data_i),
        .data_o      (data_o),
        .data_valid_o(data_valid_o),
        .data_dst_o  (data_dst_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    // Transaction-level model: a line array plus at most one outstanding read with a due edge.
    logic [CLS-1:0] m_mem [NL];
    bit             m_pend;
    int             m_due;
    logic           m_paddr;
    logic [1:0]     m_powner;
    int             m_edge;
    logic [CLS-1:0] m_data;
    logic           m_valid;
    logic [1:0]     m_dst;
    logic           m_busy;
    logic           m_err;

    task automatic model_reset();
        m_mem[0] = CLS'(0);
        m_mem[1] = CLS'(1);
        m_pend   = 1'b0;
        m_due    = 0;
        m_paddr  = 1'b0;
        m_powner = 2'd0;
        m_edge   = 0;
        m_data   = '0;
        m_valid  = 1'b0;
        m_dst    = 2'd0;
        m_busy   = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_edge(input logic [1:0] msg, input logic [1:0] addr,
                              input logic [1:0] owner, input logic flush,
                              input logic [CLS-1:0] data);
        logic busy_before;
        logic legal;
        busy_before = m_busy;
        legal       = (addr < 2'(NL));
        m_edge++;
        if (flush) begin
            if (msg == 2'b11 || !legal) m_err = 1'b1;
            else m_mem[addr[0]] = data;
        end else if (msg == 2'b01 || msg == 2'b10) begin
            if (busy_before || !legal) begin
                m_err = 1'b1;
            end else begin
                m_pend   = 1'b1;
                m_due    = m_edge + int'(LAT);
                m_paddr  = addr[0];
                m_powner = owner;
            end
        end
        m_valid = m_pend && (m_edge == m_due);
        m_data  = m_valid ? m_mem[m_paddr] : '0;
        if (m_valid) m_dst = m_powner;
        m_busy = m_pend && (m_edge <= m_due);
        if (m_pend && m_edge > m_due) m_pend = 1'b0;
    endtask

    task automatic step(input logic [1:0] msg, input logic [1:0] addr, input logic [1:0] owner,
                        input logic flush, input logic [CLS-1:0] data);
        bus_msg_i    = msg;
        addr_i       = addr;
        owner_i      = owner;
        flush_i      = flush;
        flush_data_i = data;
        @(posedge clk_i);
        model_edge(msg, addr, owner, flush, data);
        #1;
    endtask

    task automatic idle();
        step(2'b00, 2'd0, 2'd0, 1'b0, '0);
    endtask

    task automatic check_model(input string name);
        n_vec++;
        if (data_o !== m_data || data_valid_o !== m_valid || data_dst_o !== m_dst ||
            busy_o !== m_busy || err_o !== m_err) begin
            n_bad++;
            $display("FAIL %s: got data=%h valid=%b dst=%0d busy=%b err=%b, expected data=%h valid=%b dst=%0d busy=%b err=%b",
                     name, data_o, data_valid_o, data_dst_o, busy_o, err_o,
                     m_data, m_valid, m_dst, m_busy, m_err);
        end
    endtask

    task automatic check_val(input string name, input logic [CLS-1:0] got,
                             input logic [CLS-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reset asserted away from the clock edge; outputs must clear without waiting for a clock.
    task automatic do_reset(input string name);
        rst_i = 1'b1;
        #1;
        model_reset();
        check_model(name);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    typedef struct {
        logic [1:0]     msg;
        logic [1:0]     addr;
        logic [1:0]     owner;
        logic           flush;
        logic [CLS-1:0] data;
        logic           valid;
        logic [CLS-1:0] exp_data;
        logic [1:0]     dst;
        logic           busy;
        logic           err;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] msg, input logic [1:0] addr,
                                input logic [1:0] owner, input logic flush,
                                input logic [CLS-1:0] data, input logic valid,
                                input logic [CLS-1:0] ed, input logic [1:0] dst,
                                input logic busy, input logic err);
        vec_t v;
        v.msg = msg; v.addr = addr; v.owner = owner; v.flush = flush; v.data = data;
        v.valid = valid; v.exp_data = ed; v.dst = dst; v.busy = busy; v.err = err;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // Plain BusRd of line 1 for processor 2, response on the third edge after capture.
        tbl.push_back(mk(2'b01, 2'd1, 2'd2, 1'b0, '0,       1'b0, '0,       2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 1'b0, '0,       1'b0, '0,       2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 1'b0, '0,       1'b0, '0,       2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 1'b0, '0,       1'b1, CLS'(1),  2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 1'b0, '0,       1'b0, '0,       2'd2, 1'b0, 1'b0));
        // Writeback to line 0, then BusRdX of line 0 returns the written value.
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 1'b1, CLS'(8'hA5), 1'b0, '0,    2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(2'b10, 2'd0, 2'd1, 1'b0, '0,       1'b0, '0,       2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 1'b0, '0,       1'b0, '0,       2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 1'b0, '0,       1'b0, '0,       2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 1'b0, '0,       1'b1, CLS'(8'hA5), 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 1'b0, '0,       1'b0, '0,       2'd1, 1'b0, 1'b0));
        // Cache-to-cache BusRd: no response, not busy, but memory is updated.
        tbl.push_back(mk(2'b01, 2'd1, 2'd3, 1'b1, CLS'(8'h77), 1'b0, '0,    2'd1, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 1'b0, '0,       1'b0, '0,       2'd1, 1'b0, 1'b0));
        tbl.push_back(mk(2'b01, 2'd1, 2'd0, 1'b0, '0,       1'b0, '0,       2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 1'b0, '0,       1'b0, '0,       2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 1'b0, '0,       1'b0, '0,       2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 1'b0, '0,       1'b1, CLS'(8'h77), 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 1'b0, '0,       1'b0, '0,       2'd0, 1'b0, 1'b0));

        rst_i        = 1'b1;
        bus_msg_i    = 2'b00;
        addr_i       = 2'd0;
        owner_i      = 2'd0;
        flush_i      = 1'b0;
        flush_data_i = '0;
        model_reset();
        @(negedge clk_i);
        check_model("reset_state");
        rst_i = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].msg, tbl[i].addr, tbl[i].owner, tbl[i].flush, tbl[i].data);
            n_vec++;
            if (data_o !== tbl[i].exp_data || data_valid_o !== tbl[i].valid ||
                data_dst_o !== tbl[i].dst || busy_o !== tbl[i].busy || err_o !== tbl[i].err) begin
                n_bad++;
                $display("FAIL table[%0d]: got data=%h valid=%b dst=%0d busy=%b err=%b, expected data=%h valid=%b dst=%0d busy=%b err=%b",
                         i, data_o, data_valid_o, data_dst_o, busy_o, err_o,
                         tbl[i].exp_data, tbl[i].valid, tbl[i].dst, tbl[i].busy, tbl[i].err);
            end
        end

        // Writeback on the response edge is forwarded; one edge later it is not.
        step(2'b01, 2'd0, 2'd3, 1'b0, '0);          check_model("fwd_capture");
        idle();                                      check_model("fwd_wait1");
        idle();                                      check_model("fwd_wait2");
        step(2'b00, 2'd0, 2'd0, 1'b1, CLS'(8'h3C)); check_model("fwd_resp");
        check_val("fwd_data", data_o, CLS'(8'h3C));
        step(2'b00, 2'd0, 2'd0, 1'b1, CLS'(8'h99)); check_model("fwd_late");
        idle();                                      check_model("fwd_idle");

        // Read while busy and an illegal flushed BusUpgr both raise err; response still arrives.
        step(2'b01, 2'd1, 2'd1, 1'b0, '0);          check_model("err_capture");
        step(2'b01, 2'd0, 2'd2, 1'b0, '0);          check_model("err_rd_busy");
        check_val("err_rd_busy_flag", CLS'(err_o), CLS'(1));
        step(2'b11, 2'd0, 2'd0, 1'b1, '1);          check_model("err_upgr_flush");
        step(2'b00, 2'd0, 2'd0, 1'b0, '0);          check_model("err_resp");
        check_val("err_resp_data", data_o, CLS'(8'h77));
        for (int i = 0; i < 2; i++) begin
            idle();                                  check_model("err_after");
        end
        step(2'b01, 2'd0, 2'd0, 1'b0, '0);          check_model("err_rd0");
        for (int i = 0; i < 4; i++) begin
            idle();                                  check_model("err_rd0_wait");
        end
        check_val("err_sticky", CLS'(err_o), CLS'(1));

        // Reset in the middle of WAIT drops the pending read and reloads the array.
        do_reset("reset_clear_err");
        step(2'b01, 2'd0, 2'd1, 1'b1, CLS'(8'h55)); check_model("rst_c2c");
        idle();                                      check_model("rst_gap");
        step(2'b01, 2'd0, 2'd1, 1'b0, '0);          check_model("rst_capture");
        idle();                                      check_model("rst_wait");
        do_reset("reset_mid_wait");
        for (int i = 0; i < 6; i++) begin
            idle();                                  check_model("rst_no_resp");
        end
        for (int a = 0; a < 2; a++) begin
            step(2'b01, 2'(a), 2'd3, 1'b0, '0);     check_model("rst_reload_cap");
            for (int i = 0; i < 4; i++) begin
                idle();                              check_model("rst_reload");
            end
        end

        // Randomized traffic, mostly honouring busy_o, with periodic resets.
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [1:0]     msg;
            logic [1:0]     addr;
            logic           flush;
            logic [CLS-1:0] data;
            if (i % 150 == 149) begin
                do_reset("rand_reset");
            end
            r     = int'($urandom_range(0, 99));
            addr  = ($urandom_range(0, 15) == 0) ? 2'(2 + $urandom_range(0, 1))
                                                 : 2'($urandom_range(0, 1));
            data  = {$urandom, $urandom, $urandom, $urandom};
            msg   = 2'b00;
            flush = 1'b0;
            if (r < 3) begin
                msg = 2'b11; flush = 1'b1;
            end else if (r < 25) begin
                flush = 1'b1;
            end else if (r < 38) begin
                msg = 2'($urandom_range(1, 2)); flush = 1'b1;
            end else if (r < 60) begin
                msg = 2'($urandom_range(1, 2));
                if (m_busy && $urandom_range(0, 9) != 0) msg = 2'b00;
            end else if (r < 66) begin
                msg = 2'b11;
            end
            step(msg, addr, 2'($urandom_range(0, 3)), flush, data);
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
